// File: rtl/exe_skid_buf_pkg.sv
// ============================================================================
// Module      : cpu_params_pkg / cpu_structs_pkg
// Description : Shared widths, buffer depth and the EXE->MEM buffer entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_params_pkg;
    localparam int EXE_BUF_DEPTH = 2;
    localparam int CPU_RSZ       = 32;
    localparam int CPU_PC_SZ     = 32;
    localparam int CPU_GPR_ASZ   = 5;
endpackage : cpu_params_pkg

package cpu_structs_pkg;
    import cpu_params_pkg::*;

    typedef struct packed {
        logic [CPU_RSZ-1:0]     rd_data;
        logic [CPU_GPR_ASZ-1:0] rd_addr;
        logic                   rd_wr;
        logic [CPU_PC_SZ-1:0]   pc;
    } EXE_BUF_ENTRY_TYPE;
endpackage : cpu_structs_pkg

`default_nettype wire

// File: rtl/exe_skid_buf_fwd_cmp.sv
// ============================================================================
// Module      : exe_fwd_cmp
// Description : Two-entry register-bypass lookup; the youngest matching entry wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_fwd_cmp #(
    parameter int RSZ     = 32,
    parameter int GPR_ASZ = 5
) (
    input  logic [RSZ-1:0]     ent0_data,
    input  logic [GPR_ASZ-1:0] ent0_addr,
    input  logic               ent0_wr,
    input  logic [RSZ-1:0]     ent1_data,
    input  logic [GPR_ASZ-1:0] ent1_addr,
    input  logic               ent1_wr,
    input  logic [1:0]         ent_valid,
    input  logic               young_idx,
    input  logic [GPR_ASZ-1:0] lookup_addr,
    output logic               hit,
    output logic [RSZ-1:0]     data
);

    logic [1:0]     w_match;
    logic           w_young_hit;
    logic           w_old_hit;
    logic [RSZ-1:0] w_young_data;
    logic [RSZ-1:0] w_old_data;

    // x0 is hardwired zero, so it never forwards
    assign w_match[0] = ent_valid[0] & ent0_wr & (ent0_addr == lookup_addr) & (lookup_addr != '0);
    assign w_match[1] = ent_valid[1] & ent1_wr & (ent1_addr == lookup_addr) & (lookup_addr != '0);

    assign w_young_hit  = young_idx ? w_match[1] : w_match[0];
    assign w_old_hit    = young_idx ? w_match[0] : w_match[1];
    assign w_young_data = young_idx ? ent1_data  : ent0_data;
    assign w_old_data   = young_idx ? ent0_data  : ent1_data;

    assign hit  = w_young_hit | w_old_hit;
    assign data = w_young_hit ? w_young_data : (w_old_hit ? w_old_data : '0);

endmodule : exe_fwd_cmp

`default_nettype wire

// File: rtl/exe_skid_buf.sv
// ============================================================================
// Module      : exe_skid_buf
// Description : Two-entry registered EXE->MEM skid buffer with optional bypass
//               lookup (enabled by defining EXE_FWD_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exe_skid_buf
    import cpu_params_pkg::*;
    import cpu_structs_pkg::*;
#(
    parameter int RSZ     = CPU_RSZ,
    parameter int PC_SZ   = CPU_PC_SZ,
    parameter int GPR_ASZ = CPU_GPR_ASZ
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               flush_in,
    input  logic               exe_valid_in,
    output logic               exe_rdy_out,
    input  logic [RSZ-1:0]     afu_rd_data_in,
    input  logic [GPR_ASZ-1:0] exe_rd_addr_in,
    input  logic               exe_rd_wr_in,
    input  logic [PC_SZ-1:0]   exe_pc_in,
    output logic               mem_valid_out,
    input  logic               mem_rdy_in,
    output logic [RSZ-1:0]     mem_rd_data_out,
    output logic [GPR_ASZ-1:0] mem_rd_addr_out,
    output logic               mem_rd_wr_out,
    output logic [PC_SZ-1:0]   mem_pc_out,
    input  logic [GPR_ASZ-1:0] fwd_rs1_addr_in,
    input  logic [GPR_ASZ-1:0] fwd_rs2_addr_in,
    output logic               fwd_rs1_hit_out,
    output logic               fwd_rs2_hit_out,
    output logic [RSZ-1:0]     fwd_rs1_data_out,
    output logic [RSZ-1:0]     fwd_rs2_data_out
);

    EXE_BUF_ENTRY_TYPE r_entry [EXE_BUF_DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              r_exe_rdy;

    logic              w_push;
    logic              w_pop;
    logic [1:0]        w_next_count;
    EXE_BUF_ENTRY_TYPE w_head;

    assign w_push = exe_valid_in & r_exe_rdy;
    assign w_pop  = (r_count != 2'd0) & mem_rdy_in;

    always_comb begin
        w_next_count = r_count;
        if (flush_in) begin
            w_next_count = 2'd0;
        end else if (w_push && !w_pop) begin
            w_next_count = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_next_count = r_count - 2'd1;
        end
    end

    // Flush resets the bookkeeping only; entry storage keeps its stale contents
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < EXE_BUF_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_exe_rdy <= 1'b1;
        end else if (flush_in) begin
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_exe_rdy <= 1'b1;
        end else begin
            if (w_push) begin
                r_entry[r_wr_ptr].rd_data <= afu_rd_data_in;
                r_entry[r_wr_ptr].rd_addr <= exe_rd_addr_in;
                r_entry[r_wr_ptr].rd_wr   <= exe_rd_wr_in;
                r_entry[r_wr_ptr].pc      <= exe_pc_in;
                r_wr_ptr                  <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count   <= w_next_count;
            r_exe_rdy <= (w_next_count != 2'd2);
        end
    end

    assign w_head          = r_entry[r_rd_ptr];
    assign exe_rdy_out     = r_exe_rdy;
    assign mem_valid_out   = (r_count != 2'd0);
    assign mem_rd_data_out = w_head.rd_data;
    assign mem_rd_addr_out = w_head.rd_addr;
    assign mem_rd_wr_out   = w_head.rd_wr;
    assign mem_pc_out      = w_head.pc;

`ifdef EXE_FWD_EN
    logic [1:0] w_ent_valid;

    // With one entry held, only the head slot is live
    assign w_ent_valid[0] = (r_count == 2'd2) | ((r_count == 2'd1) & ~r_rd_ptr);
    assign w_ent_valid[1] = (r_count == 2'd2) | ((r_count == 2'd1) &  r_rd_ptr);

    exe_fwd_cmp #(
        .RSZ     (RSZ),
        .GPR_ASZ (GPR_ASZ)
    ) u_fwd_rs1 (
        .ent0_data   (r_entry[0].rd_data),
        .ent0_addr   (r_entry[0].rd_addr),
        .ent0_wr     (r_entry[0].rd_wr),
        .ent1_data   (r_entry[1].rd_data),
        .ent1_addr   (r_entry[1].rd_addr),
        .ent1_wr     (r_entry[1].rd_wr),
        .ent_valid   (w_ent_valid),
        .young_idx   (~r_wr_ptr),
        .lookup_addr (fwd_rs1_addr_in),
        .hit         (fwd_rs1_hit_out),
        .data        (fwd_rs1_data_out)
    );

    exe_fwd_cmp #(
        .RSZ     (RSZ),
        .GPR_ASZ (GPR_ASZ)
    ) u_fwd_rs2 (
        .ent0_data   (r_entry[0].rd_data),
        .ent0_addr   (r_entry[0].rd_addr),
        .ent0_wr     (r_entry[0].rd_wr),
        .ent1_data   (r_entry[1].rd_data),
        .ent1_addr   (r_entry[1].rd_addr),
        .ent1_wr     (r_entry[1].rd_wr),
        .ent_valid   (w_ent_valid),
        .young_idx   (~r_wr_ptr),
        .lookup_addr (fwd_rs2_addr_in),
        .hit         (fwd_rs2_hit_out),
        .data        (fwd_rs2_data_out)
    );
`else
    logic w_fwd_addr_unused;

    assign w_fwd_addr_unused = ^{fwd_rs1_addr_in, fwd_rs2_addr_in};
    assign fwd_rs1_hit_out   = 1'b0;
    assign fwd_rs2_hit_out   = 1'b0;
    assign fwd_rs1_data_out  = '0;
    assign fwd_rs2_data_out  = '0;
`endif

endmodule : exe_skid_buf

`default_nettype wire

// File: tb/tb_exe_skid_buf.sv
// ============================================================================
// Module      : tb_exe_skid_buf
// Description : Directed self-checking bench for exe_skid_buf (EXE_FWD_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exe_skid_buf;

`ifdef EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush_in;
    logic        exe_valid_in;
    logic        exe_rdy_out;
    logic [31:0] afu_rd_data_in;
    logic [4:0]  exe_rd_addr_in;
    logic        exe_rd_wr_in;
    logic [31:0] exe_pc_in;
    logic        mem_valid_out;
    logic        mem_rdy_in;
    logic [31:0] mem_rd_data_out;
    logic [4:0]  mem_rd_addr_out;
    logic        mem_rd_wr_out;
    logic [31:0] mem_pc_out;
    logic [4:0]  fwd_rs1_addr_in;
    logic [4:0]  fwd_rs2_addr_in;
    logic        fwd_rs1_hit_out;
    logic        fwd_rs2_hit_out;
    logic [31:0] fwd_rs1_data_out;
    logic [31:0] fwd_rs2_data_out;

    int checks = 0;
    int errors = 0;

    exe_skid_buf u_dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .flush_in         (flush_in),
        .exe_valid_in     (exe_valid_in),
        .exe_rdy_out      (exe_rdy_out),
        .afu_rd_data_in   (afu_rd_data_in),
        .exe_rd_addr_in   (exe_rd_addr_in),
        .exe_rd_wr_in     (exe_rd_wr_in),
        .exe_pc_in        (exe_pc_in),
        .mem_valid_out    (mem_valid_out),
        .mem_rdy_in       (mem_rdy_in),
        .mem_rd_data_out  (mem_rd_data_out),
        .mem_rd_addr_out  (mem_rd_addr_out),
        .mem_rd_wr_out    (mem_rd_wr_out),
        .mem_pc_out       (mem_pc_out),
        .fwd_rs1_addr_in  (fwd_rs1_addr_in),
        .fwd_rs2_addr_in  (fwd_rs2_addr_in),
        .fwd_rs1_hit_out  (fwd_rs1_hit_out),
        .fwd_rs2_hit_out  (fwd_rs2_hit_out),
        .fwd_rs1_data_out (fwd_rs1_data_out),
        .fwd_rs2_data_out (fwd_rs2_data_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd,
                         input logic wr, input logic [31:0] pc);
        exe_valid_in   = v;
        afu_rd_data_in = d;
        exe_rd_addr_in = rd;
        exe_rd_wr_in   = wr;
        exe_pc_in      = pc;
    endtask

    initial begin
        reset_in        = 1'b1;
        flush_in        = 1'b0;
        mem_rdy_in      = 1'b0;
        fwd_rs1_addr_in = 5'd0;
        fwd_rs2_addr_in = 5'd0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        step();
        reset_in = 1'b0;

        // Reset state
        check("rst_valid", mem_valid_out, 1'b0);
        check("rst_rdy", exe_rdy_out, 1'b1);
        check("rst_data", mem_rd_data_out, 32'h0);
        check("rst_addr", mem_rd_addr_out, 5'd0);
        check("rst_wr", mem_rd_wr_out, 1'b0);
        check("rst_pc", mem_pc_out, 32'h0);
        check("rst_hit1", fwd_rs1_hit_out, 1'b0);

        // Single push with MEM ready
        mem_rdy_in = 1'b1;
        drive(1'b1, 32'h5, 5'd3, 1'b1, 32'h100);
        step();
        check("t1_valid", mem_valid_out, 1'b1);
        check("t1_data", mem_rd_data_out, 32'h5);
        check("t1_addr", mem_rd_addr_out, 5'd3);
        check("t1_wr", mem_rd_wr_out, 1'b1);
        check("t1_pc", mem_pc_out, 32'h100);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        check("t1_empty", mem_valid_out, 1'b0);
        check("t1_rdy", exe_rdy_out, 1'b1);

        // Fill with MEM stalled
        mem_rdy_in = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1, 32'h104);
        step();
        check("f1_data", mem_rd_data_out, 32'h11);
        check("f1_rdy", exe_rdy_out, 1'b1);
        drive(1'b1, 32'h22, 5'd2, 1'b1, 32'h108);
        step();
        check("f2_rdy", exe_rdy_out, 1'b0);
        check("f2_data", mem_rd_data_out, 32'h11);
        drive(1'b1, 32'h99, 5'd9, 1'b1, 32'h10c);
        step();
        check("full_hold_data", mem_rd_data_out, 32'h11);
        check("full_hold_rdy", exe_rdy_out, 1'b0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        mem_rdy_in = 1'b1;
        step();
        check("d1_data", mem_rd_data_out, 32'h22);
        check("d1_pc", mem_pc_out, 32'h108);
        check("d1_valid", mem_valid_out, 1'b1);
        check("d1_rdy", exe_rdy_out, 1'b1);

        // Simultaneous push and pop at count 1
        drive(1'b1, 32'h33, 5'd4, 1'b1, 32'h110);
        step();
        check("pp_data", mem_rd_data_out, 32'h33);
        check("pp_valid", mem_valid_out, 1'b1);
        check("pp_rdy", exe_rdy_out, 1'b1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        check("pp_drain", mem_valid_out, 1'b0);

        // Flush while full with a push offered
        mem_rdy_in = 1'b0;
        drive(1'b1, 32'h44, 5'd5, 1'b1, 32'h114);
        step();
        drive(1'b1, 32'h55, 5'd6, 1'b1, 32'h118);
        step();
        check("fl_full_rdy", exe_rdy_out, 1'b0);
        flush_in = 1'b1;
        drive(1'b1, 32'h66, 5'd7, 1'b1, 32'h11c);
        step();
        check("fl_valid", mem_valid_out, 1'b0);
        check("fl_rdy", exe_rdy_out, 1'b1);
        flush_in = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        step();
        check("fl_no_ghost", mem_valid_out, 1'b0);
        drive(1'b1, 32'h77, 5'd9, 1'b1, 32'h120);
        step();
        check("fl_new_data", mem_rd_data_out, 32'h77);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        mem_rdy_in = 1'b1;
        step();
        check("fl_new_drain", mem_valid_out, 1'b0);

        // Bypass: two entries for x7, younger must win
        mem_rdy_in = 1'b0;
        drive(1'b1, 32'hAA, 5'd7, 1'b1, 32'h200);
        step();
        drive(1'b1, 32'hBB, 5'd7, 1'b1, 32'h204);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        fwd_rs1_addr_in = 5'd7;
        fwd_rs2_addr_in = 5'd0;
        #1;
        check("bp_head", mem_rd_data_out, 32'hAA);
        check("bp_young_hit", fwd_rs1_hit_out, FWD);
        check("bp_young_data", fwd_rs1_data_out, FWD ? 32'hBB : 32'h0);
        check("bp_x0_hit", fwd_rs2_hit_out, 1'b0);
        mem_rdy_in = 1'b1;
        step();
        mem_rdy_in = 1'b0;
        check("bp_one_data", fwd_rs1_data_out, FWD ? 32'hBB : 32'h0);
        drive(1'b1, 32'hDD, 5'd0, 1'b1, 32'h208);
        step();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        check("bp_x0_entry_hit", fwd_rs2_hit_out, 1'b0);
        check("bp_x0_entry_data", fwd_rs2_data_out, 32'h0);
        check("bp_old_hit", fwd_rs1_hit_out, FWD);
        check("bp_old_data", fwd_rs1_data_out, FWD ? 32'hBB : 32'h0);
        fwd_rs2_addr_in = 5'd5;
        #1;
        check("bp_miss_hit", fwd_rs2_hit_out, 1'b0);
        check("bp_full_rdy", exe_rdy_out, 1'b0);

        // Asynchronous reset while full
        #2;
        reset_in = 1'b1;
        #1;
        check("ar_valid", mem_valid_out, 1'b0);
        check("ar_rdy", exe_rdy_out, 1'b1);
        check("ar_data", mem_rd_data_out, 32'h0);
        check("ar_pc", mem_pc_out, 32'h0);
        check("ar_hit1", fwd_rs1_hit_out, 1'b0);
        check("ar_data1", fwd_rs1_data_out, 32'h0);
        step();
        reset_in = 1'b0;
        step();
        check("ar_post_valid", mem_valid_out, 1'b0);
        check("ar_post_rdy", exe_rdy_out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_exe_skid_buf

`default_nettype wire
